time_mode_controller: RTL and testbench

TIME_MODE_CONTROLLER -- requirements
Module: time_mode_controller

---
 rtl/time_ctrl_pkg.sv | 58 +++++
 rtl/adj_timeout.sv | 39 +++
 rtl/time_mode_controller.sv | 189 ++++++++++++++++++
 tb/tb_time_mode_controller.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_ctrl_pkg.sv
// Shared state codes, adjust-pulse bit positions and alarm constants.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package time_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_CLOCK    = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_AL_HOUR  = 3'd3,
    ST_AL_MIN   = 3'd4
  } state_t;

  // Bit positions inside time_adj / alarm_adj: {hour_up, hour_dn, min_up, min_dn}
  localparam int ADJ_HOUR_UP = 3;
  localparam int ADJ_HOUR_DN = 2;
  localparam int ADJ_MIN_UP  = 1;
  localparam int ADJ_MIN_DN  = 0;

  // Number of 1 Hz ticks the alarm sounds before silencing itself
  localparam int ALARM_TICKS = 60;
  localparam int ALARM_CNT_W = $clog2(ALARM_TICKS);

  function automatic logic is_adjust(input state_t s);
    return (s == ST_SET_HOUR) || (s == ST_SET_MIN) ||
           (s == ST_AL_HOUR)  || (s == ST_AL_MIN);
  endfunction

  // States in which the time of day is frozen for editing
  function automatic logic is_time_set(input state_t s);
    return (s == ST_SET_HOUR) || (s == ST_SET_MIN);
  endfunction

  // Forward step through the adjust ring
  function automatic state_t adj_next(input state_t s);
    state_t r;
    case (s)
      ST_SET_HOUR: r = ST_SET_MIN;
      ST_SET_MIN:  r = ST_AL_HOUR;
      ST_AL_HOUR:  r = ST_AL_MIN;
      default:     r = ST_SET_HOUR;
    endcase
    return r;
  endfunction

  // Reverse step through the adjust ring
  function automatic state_t adj_prev(input state_t s);
    state_t r;
    case (s)
      ST_SET_HOUR: r = ST_AL_MIN;
      ST_SET_MIN:  r = ST_SET_HOUR;
      ST_AL_HOUR:  r = ST_SET_MIN;
      default:     r = ST_AL_HOUR;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/adj_timeout.sv
// Idle timer for adjust modes: counts ticks and flags when TIMEOUT_S is reached.
// Latency: expired is registered-count based, asserted the cycle after the final tick.
// Backpressure: none; clr overrides tick and the count saturates at TIMEOUT_S.
module adj_timeout #(
  parameter int TIMEOUT_S = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clr,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_S + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise advance on tick until saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != CW'(TIMEOUT_S))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CW'(TIMEOUT_S));

endmodule

// File: rtl/time_mode_controller.sv
// Alarm-clock mode FSM: button navigation, counter enables, adjust pulses, blink, alarm.
// Latency: every output is registered; a response appears one cycle after its cause.
// Backpressure: none; inputs are single-cycle pulses/levels and are never stalled.
module time_mode_controller #(
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_c,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       sec_max,
  input  logic       min_max,
  input  logic       hour_max,
  input  logic       alarm_match,
  output logic [2:0] mode,
  output logic       sec_en,
  output logic       min_en,
  output logic       hour_en,
  output logic       sec_clr,
  output logic [3:0] time_adj,
  output logic [3:0] alarm_adj,
  output logic       blink,
  output logic       alarm_on
);

  import time_ctrl_pkg::*;

  state_t                 state_q, state_d;
  logic                   sec_en_q, sec_en_d;
  logic                   min_en_q, min_en_d;
  logic                   hour_en_q, hour_en_d;
  logic                   sec_clr_q, sec_clr_d;
  logic [3:0]             time_adj_q, time_adj_d;
  logic [3:0]             alarm_adj_q, alarm_adj_d;
  logic                   blink_q, blink_d;
  logic                   alarm_on_q, alarm_on_d;
  logic [ALARM_CNT_W-1:0] dur_q, dur_d;

  logic any_btn, adj_up, adj_dn, alarm_clr_btn;
  logic to_tick, to_clr, to_expired;
  logic hour_max_unused;

  // hour_max is part of the counter status bundle; the hour counter owns its wrap
  assign hour_max_unused = hour_max;

  // Button priority c > l > r > u > d: up/down only act when nothing higher is pressed
  assign any_btn = btn_c | btn_l | btn_r | btn_u | btn_d;
  assign adj_up  = btn_u & ~(btn_c | btn_l | btn_r);
  assign adj_dn  = btn_d & ~(btn_c | btn_l | btn_r | btn_u);

  // Next state and all next-output values, decoded from the current (pre-transition) state
  always_comb begin
    state_d       = state_q;
    alarm_clr_btn = 1'b0;
    sec_en_d      = 1'b0;
    min_en_d      = 1'b0;
    hour_en_d     = 1'b0;
    sec_clr_d     = 1'b0;
    time_adj_d    = '0;
    alarm_adj_d   = '0;
    blink_d       = blink_q;
    alarm_on_d    = alarm_on_q;
    dur_d         = dur_q;

    case (state_q)
      ST_CLOCK: begin
        if (btn_c) begin
          if (alarm_on_q) alarm_clr_btn = 1'b1;
          else            state_d       = ST_SET_HOUR;
        end
      end
      ST_SET_HOUR, ST_SET_MIN, ST_AL_HOUR, ST_AL_MIN: begin
        if (btn_c)                            state_d = ST_CLOCK;
        else if (btn_l)                       state_d = adj_prev(state_q);
        else if (btn_r)                       state_d = adj_next(state_q);
        else if (!btn_u && !btn_d && to_expired) state_d = ST_CLOCK;
      end
      default: state_d = ST_CLOCK;
    endcase

    // Time keeps running everywhere except while the time itself is being edited
    sec_en_d  = tick_1hz & ((state_q == ST_CLOCK) || (state_q == ST_AL_HOUR) ||
                            (state_q == ST_AL_MIN));
    min_en_d  = sec_en_d & sec_max;
    hour_en_d = min_en_d & min_max;

    // Leaving a time-edit mode restarts the minute cleanly
    sec_clr_d = is_time_set(state_q) && (state_d != state_q);

    case (state_q)
      ST_SET_HOUR: begin
        time_adj_d[ADJ_HOUR_UP] = adj_up;
        time_adj_d[ADJ_HOUR_DN] = adj_dn;
      end
      ST_SET_MIN: begin
        time_adj_d[ADJ_MIN_UP] = adj_up;
        time_adj_d[ADJ_MIN_DN] = adj_dn;
      end
      ST_AL_HOUR: begin
        alarm_adj_d[ADJ_HOUR_UP] = adj_up;
        alarm_adj_d[ADJ_HOUR_DN] = adj_dn;
      end
      ST_AL_MIN: begin
        alarm_adj_d[ADJ_MIN_UP] = adj_up;
        alarm_adj_d[ADJ_MIN_DN] = adj_dn;
      end
      default: ;
    endcase

    // Blink: off outside adjust, forced on at entry, toggled each second while editing
    if (!is_adjust(state_d))      blink_d = 1'b0;
    else if (state_d != state_q)  blink_d = 1'b1;
    else if (tick_1hz)            blink_d = ~blink_q;

    // Alarm: start on a matching tick (not while editing time), stop by button or duration
    if (alarm_on_q) begin
      if (alarm_clr_btn) begin
        alarm_on_d = 1'b0;
        dur_d      = '0;
      end else if (tick_1hz) begin
        if (dur_q == ALARM_CNT_W'(ALARM_TICKS - 1)) begin
          alarm_on_d = 1'b0;
          dur_d      = '0;
        end else begin
          dur_d = dur_q + 1'b1;
        end
      end
    end else if (tick_1hz && alarm_match && !is_time_set(state_q)) begin
      alarm_on_d = 1'b1;
      dur_d      = '0;
    end
  end

  // Idle timer runs only on ticks in adjust modes; any activity or mode change restarts it
  assign to_tick = tick_1hz & is_adjust(state_q);
  assign to_clr  = any_btn | (state_d != state_q) | (state_q == ST_CLOCK);

  adj_timeout #(
    .TIMEOUT_S(TIMEOUT_S)
  ) u_adj_timeout (
    .clk    (clk),
    .reset  (reset),
    .tick   (to_tick),
    .clr    (to_clr),
    .expired(to_expired)
  );

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_CLOCK;
      sec_en_q    <= 1'b0;
      min_en_q    <= 1'b0;
      hour_en_q   <= 1'b0;
      sec_clr_q   <= 1'b0;
      time_adj_q  <= '0;
      alarm_adj_q <= '0;
      blink_q     <= 1'b0;
      alarm_on_q  <= 1'b0;
      dur_q       <= '0;
    end else begin
      state_q     <= state_d;
      sec_en_q    <= sec_en_d;
      min_en_q    <= min_en_d;
      hour_en_q   <= hour_en_d;
      sec_clr_q   <= sec_clr_d;
      time_adj_q  <= time_adj_d;
      alarm_adj_q <= alarm_adj_d;
      blink_q     <= blink_d;
      alarm_on_q  <= alarm_on_d;
      dur_q       <= dur_d;
    end
  end

  assign mode      = state_q;
  assign sec_en    = sec_en_q;
  assign min_en    = min_en_q;
  assign hour_en   = hour_en_q;
  assign sec_clr   = sec_clr_q;
  assign time_adj  = time_adj_q;
  assign alarm_adj = alarm_adj_q;
  assign blink     = blink_q;
  assign alarm_on  = alarm_on_q;

endmodule

// File: tb/tb_time_mode_controller.sv
// Self-checking bench for time_mode_controller: directed button/tick sequences.
// A mode-level model predicts every output each cycle; literal checks pin key points.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_time_mode_controller;

  localparam int TO = 10;

  // {c, l, r, u, d, tick}
  localparam logic [5:0] B_C  = 6'b100000;
  localparam logic [5:0] B_L  = 6'b010000;
  localparam logic [5:0] B_R  = 6'b001000;
  localparam logic [5:0] B_U  = 6'b000100;
  localparam logic [5:0] B_D  = 6'b000010;
  localparam logic [5:0] TK   = 6'b000001;
  localparam logic [5:0] NONE = 6'b000000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_c = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic       sec_max = 1'b0, min_max = 1'b0, hour_max = 1'b0, alarm_match = 1'b0;
  logic [2:0] mode;
  logic       sec_en, min_en, hour_en, sec_clr, blink, alarm_on;
  logic [3:0] time_adj, alarm_adj;

  time_mode_controller #(.TIMEOUT_S(TO)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .btn_c(btn_c), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
    .sec_max(sec_max), .min_max(min_max), .hour_max(hour_max), .alarm_match(alarm_match),
    .mode(mode), .sec_en(sec_en), .min_en(min_en), .hour_en(hour_en), .sec_clr(sec_clr),
    .time_adj(time_adj), .alarm_adj(alarm_adj), .blink(blink), .alarm_on(alarm_on)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (modes as integers 0..4) ----------------
  int m_mode, m_idle, m_sound, m_alarm, m_blink;
  int e_sec, e_min, e_hour, e_clr, e_tadj, e_aadj;
  int prv, nxt, win;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_idle = 0; m_sound = 0; m_alarm = 0; m_blink = 0;
      e_sec = 0; e_min = 0; e_hour = 0; e_clr = 0; e_tadj = 0; e_aadj = 0;
    end else begin
      prv = m_mode;
      win = btn_c ? 1 : btn_l ? 2 : btn_r ? 3 : btn_u ? 4 : btn_d ? 5 : 0;

      e_sec  = (tick_1hz && (prv == 0 || prv == 3 || prv == 4)) ? 1 : 0;
      e_min  = (e_sec == 1 && sec_max) ? 1 : 0;
      e_hour = (e_min == 1 && min_max) ? 1 : 0;

      e_tadj = 0;
      e_aadj = 0;
      if (win == 4 || win == 5) begin
        case (prv)
          1: e_tadj = (win == 4) ? 8 : 4;
          2: e_tadj = (win == 4) ? 2 : 1;
          3: e_aadj = (win == 4) ? 8 : 4;
          4: e_aadj = (win == 4) ? 2 : 1;
          default: ;
        endcase
      end

      nxt = prv;
      if (prv == 0) begin
        if (win == 1 && m_alarm == 0) nxt = 1;
      end else begin
        if (win == 1)                       nxt = 0;
        else if (win == 2)                  nxt = ((prv + 2) % 4) + 1;
        else if (win == 3)                  nxt = (prv % 4) + 1;
        else if (win == 0 && m_idle >= TO)  nxt = 0;
      end
      e_clr = ((prv == 1 || prv == 2) && nxt != prv) ? 1 : 0;

      if (m_alarm == 1) begin
        if (prv == 0 && win == 1) begin
          m_alarm = 0; m_sound = 0;
        end else if (tick_1hz) begin
          m_sound++;
          if (m_sound == 60) begin m_alarm = 0; m_sound = 0; end
        end
      end else if (tick_1hz && alarm_match && prv != 1 && prv != 2) begin
        m_alarm = 1; m_sound = 0;
      end

      if (nxt != prv || win != 0 || prv == 0) m_idle = 0;
      else if (tick_1hz)                      m_idle++;

      if (nxt == 0)        m_blink = 0;
      else if (nxt != prv) m_blink = 1;
      else if (tick_1hz)   m_blink = 1 - m_blink;

      m_mode = nxt;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      cmp("mode",      32'(mode),      m_mode);
      cmp("sec_en",    32'(sec_en),    e_sec);
      cmp("min_en",    32'(min_en),    e_min);
      cmp("hour_en",   32'(hour_en),   e_hour);
      cmp("sec_clr",   32'(sec_clr),   e_clr);
      cmp("time_adj",  32'(time_adj),  e_tadj);
      cmp("alarm_adj", 32'(alarm_adj), e_aadj);
      cmp("blink",     32'(blink),     m_blink);
      cmp("alarm_on",  32'(alarm_on),  m_alarm);
    end
  end

  task automatic step(input logic [5:0] v);
    {btn_c, btn_l, btn_r, btn_u, btn_d, tick_1hz} = v;
    @(negedge clk);
    {btn_c, btn_l, btn_r, btn_u, btn_d, tick_1hz} = NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk);
    cmp("rst_mode", 32'(mode), 0);
    cmp("rst_sec_en", 32'(sec_en), 0);
    cmp("rst_time_adj", 32'(time_adj), 0);
    cmp("rst_blink", 32'(blink), 0);
    cmp("rst_alarm_on", 32'(alarm_on), 0);
    reset = 1'b0;
    cmp_en = 1'b1;
    step(NONE);

    // Full cascade on a tick at 23:59:59
    sec_max = 1'b1; min_max = 1'b1;
    step(TK);
    cmp("casc_sec", 32'(sec_en), 1);
    cmp("casc_min", 32'(min_en), 1);
    cmp("casc_hour", 32'(hour_en), 1);
    step(NONE);
    cmp("casc_off", 32'({sec_en, min_en, hour_en}), 0);
    min_max = 1'b0;
    step(TK);
    cmp("casc_part", 32'({sec_en, min_en, hour_en}), 3'b110);
    sec_max = 1'b0;
    step(NONE);

    // Navigate to SET_MIN, adjust minutes, time frozen
    step(B_C);
    cmp("nav_mode1", 32'(mode), 1);
    cmp("nav_blink", 32'(blink), 1);
    step(B_R);
    cmp("nav_mode2", 32'(mode), 2);
    cmp("nav_clr", 32'(sec_clr), 1);
    step(B_U);
    cmp("nav_minup", 32'(time_adj), 4'b0010);
    step(NONE);
    cmp("nav_adj_off", 32'(time_adj), 0);
    for (int i = 0; i < 3; i++) begin
      step(TK);
      cmp("frozen_sec_en", 32'(sec_en), 0);
      step(NONE);
    end
    cmp("blink_3tk", 32'(blink), 0);
    step(B_D);
    cmp("nav_mindn", 32'(time_adj), 4'b0001);
    step(B_C);
    cmp("nav_exit", 32'(mode), 0);

    // Priority and ring wrap
    step(B_C);
    step(B_L | B_R);
    cmp("prio_l_over_r", 32'(mode), 4);
    step(B_U | B_D);
    cmp("prio_u_over_d", 32'(alarm_adj), 4'b0010);
    step(B_R);
    cmp("wrap_fwd", 32'(mode), 1);
    cmp("wrap_no_clr", 32'(sec_clr), 0);
    step(B_L);
    step(B_L);
    cmp("wrap_rev", 32'(mode), 3);
    step(B_D);
    cmp("al_hour_dn", 32'(alarm_adj), 4'b0100);
    step(B_C);

    // Timeout after TO idle ticks
    step(B_C);
    for (int i = 0; i < TO - 1; i++) begin step(TK); step(NONE); end
    cmp("to_before", 32'(mode), 1);
    step(TK);
    cmp("to_at_tick", 32'(mode), 1);
    step(NONE);
    cmp("to_expired", 32'(mode), 0);
    cmp("to_clr", 32'(sec_clr), 1);
    step(NONE);
    cmp("to_clr_once", 32'(sec_clr), 0);

    // Button on the final tick keeps the mode
    step(B_C);
    for (int i = 0; i < TO - 1; i++) begin step(TK); step(NONE); end
    step(TK | B_U);
    cmp("to_btn_mode", 32'(mode), 1);
    cmp("to_btn_adj", 32'(time_adj), 4'b1000);
    for (int i = 0; i < 3; i++) step(NONE);
    cmp("to_btn_hold", 32'(mode), 1);
    step(B_C);

    // Centre beats up in SET_MIN
    step(B_C);
    step(B_R);
    step(B_C | B_U);
    cmp("cu_mode", 32'(mode), 0);
    cmp("cu_adj", 32'(time_adj), 0);
    cmp("cu_clr", 32'(sec_clr), 1);
    step(NONE);

    // Alarm: set, cancel by centre, then auto-clear
    alarm_match = 1'b1;
    step(TK);
    alarm_match = 1'b0;
    cmp("al_set", 32'(alarm_on), 1);
    step(NONE);
    step(B_C);
    cmp("al_cancel", 32'(alarm_on), 0);
    cmp("al_cancel_mode", 32'(mode), 0);
    alarm_match = 1'b1;
    step(TK);
    alarm_match = 1'b0;
    for (int i = 0; i < 59; i++) begin step(TK); step(NONE); end
    cmp("al_59", 32'(alarm_on), 1);
    step(TK);
    cmp("al_60", 32'(alarm_on), 0);

    // No alarm while editing time; alarm in AL_HOUR survives centre from adjust
    step(B_C);
    alarm_match = 1'b1;
    step(TK);
    alarm_match = 1'b0;
    cmp("al_sethour", 32'(alarm_on), 0);
    step(B_R);
    step(B_R);
    alarm_match = 1'b1;
    step(TK);
    alarm_match = 1'b0;
    cmp("al_alhour", 32'(alarm_on), 1);
    step(B_C);
    cmp("al_keep", 32'(alarm_on), 1);
    step(B_C);
    cmp("al_off", 32'(alarm_on), 0);

    // Asynchronous reset mid-cycle in AL_MIN
    step(B_C);
    step(B_L);
    step(B_U);
    cmp("pre_rst_adj", 32'(alarm_adj), 4'b0010);
    #2 reset = 1'b1;
    #1;
    cmp("arst_mode", 32'(mode), 0);
    cmp("arst_pulses", 32'({sec_en, min_en, hour_en, sec_clr, time_adj, alarm_adj}), 0);
    cmp("arst_blink", 32'(blink), 0);
    @(negedge clk);
    cmp("arst_hold_clr", 32'(sec_clr), 0);
    reset = 1'b0;
    step(NONE);
    cmp("post_rst_mode", 32'(mode), 0);
    cmp("post_rst_clr", 32'(sec_clr), 0);
    step(B_C);
    cmp("post_rst_enter", 32'(mode), 1);
    step(B_C);
    step(NONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
